// File: rtl/seq_addsub.sv
// seq_addsub: multi-cycle adder/subtractor that processes CHUNK bits per clock.
// The low slice is handled first, and the carry between slices is kept in a register.
// Subtraction is a + ~b + 1, so cout = 1 means no borrow occurred.
// Optional feature: define SEQ_ADDSUB_FLAGS_EN to enable the ovf and zero flags.
// When it is not defined, both flags are tied to 0 and no flag logic is built.
module seq_addsub #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);

    localparam int NCH = WIDTH / CHUNK;
    localparam int IW  = (NCH > 1) ? $clog2(NCH) : 1;
    localparam logic [IW-1:0] LAST = IW'(NCH - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state;
    state_t           state_next;

    logic [WIDTH-1:0] opa;
    logic [WIDTH-1:0] opb;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] acc_next;
    logic             carry;
    logic [IW-1:0]    idx;
    logic [CHUNK-1:0] slice_sum;
    logic             slice_cout;
    logic             accept;
    logic             last;

    // A new request is only taken when no operation is in flight.
    assign accept = start && ((state == IDLE) || (state == DONE));
    assign last   = (idx == LAST);

    // Add the current slice and merge the result into the partial sum.
    always_comb begin
        acc_next = acc;
        {slice_cout, slice_sum} = {1'b0, opa[idx*CHUNK +: CHUNK]}
                                + {1'b0, opb[idx*CHUNK +: CHUNK]}
                                + {{CHUNK{1'b0}}, carry};
        acc_next[idx*CHUNK +: CHUNK] = slice_sum;
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic. DONE can start the next operation directly, so back-to-back operations need no idle cycle.
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    state_next = start ? RUN : IDLE;
            RUN:     state_next = last ? DONE : RUN;
            DONE:    state_next = start ? RUN : IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Status outputs are decoded from the current state only.
    always_comb begin
        busy = (state == RUN);
        done = (state == DONE);
    end

    // Datapath: capture the operands, step through the slices, and publish the result on the last slice.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            opa   <= '0;
            opb   <= '0;
            acc   <= '0;
            carry <= 1'b0;
            idx   <= '0;
            s     <= '0;
            cout  <= 1'b0;
        end else if (accept) begin
            opa   <= a;
            opb   <= b ^ {WIDTH{sub}};
            acc   <= '0;
            carry <= sub;
            idx   <= '0;
        end else if (state == RUN) begin
            acc   <= acc_next;
            carry <= slice_cout;
            idx   <= last ? '0 : idx + 1'b1;
            if (last) begin
                s    <= acc_next;
                cout <= slice_cout;
            end
        end
    end

`ifdef SEQ_ADDSUB_FLAGS_EN
    // Flags update on the same edge as s. Overflow means the operand signs agree but the result sign differs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ovf  <= 1'b0;
            zero <= 1'b0;
        end else if ((state == RUN) && last) begin
            ovf  <= (opa[WIDTH-1] == opb[WIDTH-1]) && (acc_next[WIDTH-1] != opa[WIDTH-1]);
            zero <= (acc_next == '0);
        end
    end
`else
    assign ovf  = 1'b0;
    assign zero = 1'b0;
`endif

endmodule

// File: tb/tb_seq_addsub.sv
// tb_seq_addsub: self-checking bench for seq_addsub.
// It uses a 16/8 instance and a 32/8 instance, and checks them against an arithmetic reference model.
module tb_seq_addsub;

    logic        clk;
    logic        rst_n;

    logic        start16, sub16;
    logic [15:0] a16, b16;
    logic        busy16, done16, cout16, ovf16, zero16;
    logic [15:0] s16;

    logic        start32, sub32;
    logic [31:0] a32, b32;
    logic        busy32, done32, cout32, ovf32, zero32;
    logic [31:0] s32;

    int pass_cnt = 0;
    int chk_cnt  = 0;

    seq_addsub #(.WIDTH(16), .CHUNK(8)) u16 (
        .clk(clk), .rst_n(rst_n), .start(start16), .sub(sub16), .a(a16), .b(b16),
        .busy(busy16), .done(done16), .s(s16), .cout(cout16), .ovf(ovf16), .zero(zero16)
    );

    seq_addsub #(.WIDTH(32), .CHUNK(8)) u32 (
        .clk(clk), .rst_n(rst_n), .start(start32), .sub(sub32), .a(a32), .b(b32),
        .busy(busy32), .done(done32), .s(s32), .cout(cout32), .ovf(ovf32), .zero(zero32)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: integer arithmetic on the whole operands.
    function automatic void model(input int w, input logic op_sub, input logic [31:0] op_a,
                                  input logic [31:0] op_b, output logic [31:0] es,
                                  output logic ec, output logic eo, output logic ez);
        longint unsigned ua, ub, full, half, mask, r;
        longint sa, sb, sr;
        full = 64'd1 << w;
        half = full >> 1;
        mask = full - 1;
        ua = {32'd0, op_a} & mask;
        ub = {32'd0, op_b} & mask;
        if (op_sub) begin
            r  = (ua - ub) & mask;
            ec = (ua >= ub);
        end else begin
            r  = ua + ub;
            ec = (r >= full);
            r  = r & mask;
        end
        sa = (ua >= half) ? longint'(ua) - longint'(full) : longint'(ua);
        sb = (ub >= half) ? longint'(ub) - longint'(full) : longint'(ub);
        sr = op_sub ? sa - sb : sa + sb;
        eo = (sr < -longint'(half)) || (sr >= longint'(half));
        ez = (r == 0);
`ifndef SEQ_ADDSUB_FLAGS_EN
        eo = 1'b0;
        ez = 1'b0;
`endif
        es = r[31:0];
    endfunction

    // Present one request for a single edge, then drop start.
    task automatic applyStimulus(input bit wide, input logic op_sub, input logic [31:0] op_a,
                                 input logic [31:0] op_b);
        if (wide) begin
            start32 = 1'b1; sub32 = op_sub; a32 = op_a; b32 = op_b;
        end else begin
            start16 = 1'b1; sub16 = op_sub; a16 = op_a[15:0]; b16 = op_b[15:0];
        end
        tick();
        start16 = 1'b0;
        start32 = 1'b0;
    endtask

    // Run one operation, then check its latency and results against the model.
    task automatic run_op(input bit wide, input logic op_sub, input logic [31:0] op_a,
                          input logic [31:0] op_b, input string tag);
        int w, nch, lat;
        logic [31:0] es, gs;
        logic ec, eo, ez;
        w = wide ? 32 : 16;
        nch = w / 8;
        model(w, op_sub, op_a, op_b, es, ec, eo, ez);
        applyStimulus(wide, op_sub, op_a, op_b);
        lat = 0;
        while (!(wide ? done32 : done16) && lat < 40) begin
            tick();
            lat++;
        end
        gs = wide ? s32 : {16'd0, s16};
        chk_cnt++;
        if (lat != nch) $display("[TB] FAIL %s latency: got %0d expected %0d", tag, lat, nch);
        else pass_cnt++;
        chk_cnt++;
        if (gs !== es) $display("[TB] FAIL %s s: got %h expected %h", tag, gs, es);
        else pass_cnt++;
        chk_cnt++;
        if ((wide ? cout32 : cout16) !== ec)
            $display("[TB] FAIL %s cout: got %b expected %b", tag, wide ? cout32 : cout16, ec);
        else pass_cnt++;
        chk_cnt++;
        if ((wide ? ovf32 : ovf16) !== eo)
            $display("[TB] FAIL %s ovf: got %b expected %b", tag, wide ? ovf32 : ovf16, eo);
        else pass_cnt++;
        chk_cnt++;
        if ((wide ? zero32 : zero16) !== ez)
            $display("[TB] FAIL %s zero: got %b expected %b", tag, wide ? zero32 : zero16, ez);
        else pass_cnt++;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start16 = 1'b1; sub16 = 1'b0; a16 = 16'h1234; b16 = 16'h1111;
        start32 = 1'b1; sub32 = 1'b0; a32 = 32'h1234_5678; b32 = 32'h1;
        tick();
        tick();
        chk_cnt++;
        if (busy16 !== 1'b0 || busy32 !== 1'b0)
            $display("[TB] FAIL reset busy: got %b/%b expected 0/0", busy16, busy32);
        else pass_cnt++;
        chk_cnt++;
        if (done16 !== 1'b0 || done32 !== 1'b0)
            $display("[TB] FAIL reset done: got %b/%b expected 0/0", done16, done32);
        else pass_cnt++;
        chk_cnt++;
        if (s16 !== 16'd0 || s32 !== 32'd0)
            $display("[TB] FAIL reset s: got %h/%h expected 0/0", s16, s32);
        else pass_cnt++;
        chk_cnt++;
        if ({cout16, ovf16, zero16, cout32, ovf32, zero32} !== 6'b0)
            $display("[TB] FAIL reset flags: got %b expected 000000",
                     {cout16, ovf16, zero16, cout32, ovf32, zero32});
        else pass_cnt++;
        start16 = 1'b0;
        start32 = 1'b0;
        rst_n = 1'b1;
        tick();
        chk_cnt++;
        if (busy16 !== 1'b0 || busy32 !== 1'b0)
            $display("[TB] FAIL reset_start_ignored busy: got %b/%b expected 0/0", busy16, busy32);
        else pass_cnt++;
    endtask

    task automatic test_directed();
        run_op(0, 1'b1, 32'd15010, 32'd1100, "sub_15010_1100");
        run_op(0, 1'b0, 32'hFFFF, 32'h0001, "add_wrap_zero");
        run_op(0, 1'b0, 32'h7FFF, 32'h0001, "add_pos_ovf");
        run_op(0, 1'b1, 32'h8000, 32'h0001, "sub_neg_ovf");
        run_op(0, 1'b1, 32'h0000, 32'h8000, "sub_min_ovf");
        run_op(0, 1'b1, 32'h0005, 32'h0007, "sub_borrow");
        run_op(1, 1'b0, 32'h00FF_FFFF, 32'h1, "ripple32");
    endtask

    task automatic test_random();
        for (int i = 0; i < 20; i++)
            run_op(0, 1'($urandom_range(0, 1)), $urandom, $urandom, "rand16");
        for (int i = 0; i < 10; i++)
            run_op(1, 1'($urandom_range(0, 1)), $urandom, $urandom, "rand32");
    endtask

    task automatic test_hold();
        run_op(0, 1'b0, 32'h1234, 32'h0101, "hold_op");
        a16 = 16'hAAAA;
        b16 = 16'h5555;
        sub16 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_cnt++;
            if (s16 !== 16'h1335 || done16 !== 1'b0)
                $display("[TB] FAIL hold: got s=%h done=%b expected s=1335 done=0", s16, done16);
            else pass_cnt++;
        end
    endtask

    task automatic test_ignore_busy();
        logic [31:0] es, got;
        logic ec, eo, ez, gotc;
        int pulses;
        model(16, 1'b0, 32'h0F0F, 32'h0101, es, ec, eo, ez);
        applyStimulus(0, 1'b0, 32'h0F0F, 32'h0101);
        chk_cnt++;
        if (busy16 !== 1'b1) $display("[TB] FAIL busy_after_start: got %b expected 1", busy16);
        else pass_cnt++;
        start16 = 1'b1; sub16 = 1'b1; a16 = 16'h0002; b16 = 16'h0009;
        tick();
        start16 = 1'b0;
        pulses = 0;
        got = '0;
        gotc = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (done16) begin
                pulses++;
                got = {16'd0, s16};
                gotc = cout16;
            end
            tick();
        end
        chk_cnt++;
        if (pulses != 1) $display("[TB] FAIL ignore_busy pulses: got %0d expected 1", pulses);
        else pass_cnt++;
        chk_cnt++;
        if (got !== es || gotc !== ec)
            $display("[TB] FAIL ignore_busy result: got %h/%b expected %h/%b", got, gotc, es, ec);
        else pass_cnt++;
        chk_cnt++;
        if (busy16 !== 1'b0) $display("[TB] FAIL ignore_busy idle: got busy=%b expected 0", busy16);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid_run();
        int pulses;
        run_op(1, 1'b0, 32'h1111_1111, 32'h2222_2222, "pre_abort");
        applyStimulus(1, 1'b0, 32'h0000_00FF, 32'h0000_0001);
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk_cnt++;
        if (busy32 !== 1'b0 || done32 !== 1'b0)
            $display("[TB] FAIL abort status: got busy=%b done=%b expected 0/0", busy32, done32);
        else pass_cnt++;
        chk_cnt++;
        if (s32 !== 32'd0 || {cout32, ovf32, zero32} !== 3'b0)
            $display("[TB] FAIL abort outputs: got s=%h flags=%b expected 0/000", s32,
                     {cout32, ovf32, zero32});
        else pass_cnt++;
        pulses = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (done32) pulses++;
        end
        chk_cnt++;
        if (pulses != 0) $display("[TB] FAIL abort done_pulses: got %0d expected 0", pulses);
        else pass_cnt++;
        run_op(1, 1'b1, 32'h0000_1000, 32'h0000_0001, "post_abort");
    endtask

    task automatic test_back_to_back();
        logic [31:0] oa[4], ob[4], es;
        logic        osub[4];
        logic        ec, eo, ez;
        int          lat;
        oa[0] = 32'h00FF_FFFF; ob[0] = 32'h1; osub[0] = 1'b0;
        for (int i = 1; i < 4; i++) begin
            oa[i] = $urandom; ob[i] = $urandom; osub[i] = 1'($urandom_range(0, 1));
        end
        applyStimulus(1, osub[0], oa[0], ob[0]);
        for (int i = 0; i < 4; i++) begin
            model(32, osub[i], oa[i], ob[i], es, ec, eo, ez);
            lat = 0;
            while (!done32 && lat < 40) begin
                tick();
                lat++;
            end
            chk_cnt++;
            if (lat != 4) $display("[TB] FAIL b2b[%0d] latency: got %0d expected 4", i, lat);
            else pass_cnt++;
            chk_cnt++;
            if (s32 !== es || cout32 !== ec)
                $display("[TB] FAIL b2b[%0d] result: got %h/%b expected %h/%b", i, s32, cout32, es, ec);
            else pass_cnt++;
            if (i < 3) begin
                applyStimulus(1, osub[i+1], oa[i+1], ob[i+1]);
                chk_cnt++;
                if (busy32 !== 1'b1) $display("[TB] FAIL b2b[%0d] accept: got busy=%b expected 1", i, busy32);
                else pass_cnt++;
            end
        end
        tick();
    endtask

    initial begin
        rst_n = 1'b0;
        start16 = 1'b0; sub16 = 1'b0; a16 = '0; b16 = '0;
        start32 = 1'b0; sub32 = 1'b0; a32 = '0; b32 = '0;
        test_reset();
        test_directed();
        test_random();
        test_hold();
        test_ignore_busy();
        test_reset_mid_run();
        test_back_to_back();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
